// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: bridges a 32-bit pipeline memory stage to a 16-bit
// asynchronous SRAM. Each 32-bit access is split into a low half-word
// phase and a high half-word phase, each held for WAIT_CYCLES clocks.
module mem_sram_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R,
  input  logic        MEM_W,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] W_LAST = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_wr;
  logic [16:0] r_index;
  logic [31:0] r_wdata;
  logic [31:0] r_rd_data;
  logic [17:0] r_sram_addr;
  logic [17:0] w_sram_addr_nxt;
  logic        r_we_n;
  logic        w_we_n_nxt;
  logic        r_oe_n;
  logic        w_oe_n_nxt;
  logic        w_ready;
  logic        w_latch;
  logic        w_cap_lo;
  logic        w_cap_hi;
  logic        w_last;
  logic        w_req;
  logic [16:0] w_index;
  logic        w_dq_oe;
  logic [15:0] w_dq_out;

  // Word index relative to the SRAM window; byte offset bits are dropped.
  assign w_index = 17'((addr - BASE_ADDR) >> 2);
  assign w_req   = MEM_R | MEM_W;
  assign w_last  = (r_cnt == W_LAST);

  // Next-state, phase counter and next values of the registered SRAM strobes.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_sram_addr_nxt = r_sram_addr;
    w_we_n_nxt      = 1'b1;
    w_oe_n_nxt      = 1'b1;
    w_ready         = 1'b0;
    w_latch         = 1'b0;
    w_cap_lo        = 1'b0;
    w_cap_hi        = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = ~w_req;
        if (w_req) begin
          w_state_nxt     = LOW;
          w_cnt_nxt       = 4'd0;
          w_latch         = 1'b1;
          w_sram_addr_nxt = {w_index, 1'b0};
          // A simultaneous read and write request is serviced as a write.
          w_we_n_nxt      = ~MEM_W;
          w_oe_n_nxt      = MEM_W;
        end
      end
      LOW: begin
        w_we_n_nxt = ~r_wr;
        w_oe_n_nxt = r_wr;
        if (w_last) begin
          w_state_nxt     = HIGH;
          w_cnt_nxt       = 4'd0;
          w_sram_addr_nxt = {r_index, 1'b1};
          w_cap_lo        = ~r_wr;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      HIGH: begin
        if (w_last) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = 4'd0;
          w_cap_hi    = ~r_wr;
        end else begin
          w_cnt_nxt  = r_cnt + 4'd1;
          w_we_n_nxt = ~r_wr;
          w_oe_n_nxt = r_wr;
        end
      end
      DONE: begin
        w_ready     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register, counter, registered SRAM address/strobes and load data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_wr        <= 1'b0;
      r_sram_addr <= 18'd0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_rd_data   <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sram_addr <= w_sram_addr_nxt;
      r_we_n      <= w_we_n_nxt;
      r_oe_n      <= w_oe_n_nxt;
      if (w_latch)  r_wr              <= MEM_W;
      if (w_cap_lo) r_rd_data[15:0]   <= SRAM_DQ;
      if (w_cap_hi) r_rd_data[31:16]  <= SRAM_DQ;
    end
  end

  // Request operands are captured once so mid-access input changes are ignored.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_index <= w_index;
      r_wdata <= wr_data;
    end
  end

  // The bus is only driven during the two write phases; otherwise released.
  assign w_dq_oe  = r_wr && ((r_state == LOW) || (r_state == HIGH));
  assign w_dq_out = (r_state == HIGH) ? r_wdata[31:16] : r_wdata[15:0];
  assign SRAM_DQ  = w_dq_oe ? w_dq_out : 16'hzzzz;

  assign ready     = w_ready;
  assign rd_data   = r_rd_data;
  assign SRAM_ADDR = r_sram_addr;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_OE_N = r_oe_n;

endmodule

// File: doc/mem_sram_ctrl.md
MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, meaning SRAM clock cycles held per 16-bit half access (legal 1..15).
REQ-002 Parameter BASE_ADDR, default 1024, meaning pipeline byte address that maps to SRAM word 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 MEM_R  input  1  read request from memory stage; held stable while ready=0.
REQ-006 MEM_W  input  1  write request from memory stage; held stable while ready=0.
REQ-007 addr  input  32  byte address (pipeline ALU result).
REQ-008 wr_data  input  32  store data (pipeline Rm value).
REQ-009 rd_data  output  32  registered load data.
REQ-010 ready  output  1  request complete; pipeline freeze = ~ready.
REQ-011 SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SRAM_ADDR  output  18  SRAM half-word address, registered.
REQ-013 SRAM_WE_N  output  1  SRAM write enable, active-low, registered.
REQ-014 SRAM_OE_N  output  1  SRAM output enable, active-low, registered.

Function
REQ-015 FSM states IDLE, LOW, HIGH, DONE; 4-bit phase counter cnt.
REQ-016 IDLE: if MEM_W or MEM_R is 1 at a rising edge, go to LOW with cnt=0; else stay. MEM_W=MEM_R=1 is treated as write.
REQ-017 Latched op and word index = ((addr - BASE_ADDR) >> 2) truncated to 17 bits are captured on the IDLE->LOW edge; addr[1:0] is ignored.
REQ-018 LOW: SRAM_ADDR={index,1'b0}; HIGH: SRAM_ADDR={index,1'b1}.
REQ-019 Each of LOW and HIGH lasts exactly WAIT_CYCLES cycles; cnt increments each cycle; on cnt=WAIT_CYCLES-1 the machine advances (LOW->HIGH, HIGH->DONE) and cnt clears.
REQ-020 Write: SRAM_WE_N=0 and SRAM_DQ driven with wr_data[15:0] throughout LOW, wr_data[31:16] throughout HIGH; SRAM_OE_N=1.
REQ-021 Read: SRAM_OE_N=0 in LOW and HIGH, SRAM_DQ high-Z; rd_data[15:0] loads SRAM_DQ on the last LOW cycle, rd_data[31:16] on the last HIGH cycle.
REQ-022 SRAM_DQ is high-Z in every state other than write LOW/HIGH.
REQ-023 DONE lasts one cycle, then IDLE unconditionally; SRAM_WE_N=1, SRAM_OE_N=1.
REQ-024 ready is combinational: 1 in DONE; in IDLE equals ~(MEM_R|MEM_W); 0 in LOW and HIGH.
REQ-025 Latency: request seen in IDLE at edge 0 -> ready=1 during cycle 2*WAIT_CYCLES+1 (5 cycles for default).
REQ-026 A request still asserted in DONE is not restarted; a new request is accepted only from IDLE, so back-to-back accesses are separated by one IDLE cycle.
REQ-027 rd_data holds its value across writes and idle cycles until the next read updates it.
REQ-028 Request inputs changing while in LOW/HIGH are ignored (latched op/index are used).

Reset
REQ-029 rst=0 asynchronously forces state IDLE, cnt=0, rd_data=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ high-Z.
REQ-030 Reset during LOW/HIGH aborts the access immediately; after rst rises, machine is in IDLE and ready=~(MEM_R|MEM_W).

Verification
REQ-031 Write addr=1024, wr_data=0xDEADBEEF -> SRAM model word 0=0xBEEF, word 1=0xDEAD; WE_N low 2 cycles per half; ready=1 in cycle 5.
REQ-032 SRAM model words 2=0x1234, 3=0x5678; read addr=1028 -> SRAM_ADDR 2 then 3, OE_N low 4 cycles, rd_data=0x56781234 with ready=1.
REQ-033 MEM_R=MEM_W=1, addr=1032, wr_data=0x0000ABCD -> words 4=0xABCD, 5=0x0000 written; rd_data unchanged.
REQ-034 WAIT_CYCLES=1, two back-to-back writes (addr 1024, 1028) held until ready -> ready high at cycles 3 and 7, one IDLE cycle between.
REQ-035 rst=0 asserted during HIGH of a write -> WE_N=1, DQ high-Z same cycle; after release, state IDLE, rd_data=0.
REQ-036 No request for 10 cycles -> ready=1 continuously, WE_N=OE_N=1, DQ high-Z.
